// File: rtl/reservation_station_if.sv
// reservation_station_if: dispatch, CDB and issue signals between pipeline and reservation station
interface reservation_station_if #(
   parameter int ENTRY_NUM = 4,
   parameter int ENTRY_SEL = 2,
   parameter int DATA_LEN  = 32,
   parameter int TAG_LEN   = 6,
   parameter int OP_LEN    = 4
);
   logic                 flush_i;
   logic [ENTRY_NUM-1:0] busy_o;
   logic                 we_1_i, we_2_i;
   logic [ENTRY_SEL-1:0] waddr_1_i, waddr_2_i;
   logic [OP_LEN-1:0]    op_1_i, op_2_i;
   logic [TAG_LEN-1:0]   dst_1_i, dst_2_i;
   logic [DATA_LEN-1:0]  src1_1_i, src1_2_i, src2_1_i, src2_2_i;
   logic                 src1v_1_i, src1v_2_i, src2v_1_i, src2v_2_i;
   logic                 cdb_valid_i;
   logic [TAG_LEN-1:0]   cdb_tag_i;
   logic [DATA_LEN-1:0]  cdb_data_i;
   logic                 issue_valid_o;
   logic                 issue_ready_i;
   logic [ENTRY_SEL-1:0] issue_entry_o;
   logic [OP_LEN-1:0]    issue_op_o;
   logic [TAG_LEN-1:0]   issue_dst_o;
   logic [DATA_LEN-1:0]  issue_src1_o, issue_src2_o;

   modport master (
      output flush_i, we_1_i, we_2_i, waddr_1_i, waddr_2_i, op_1_i, op_2_i, dst_1_i, dst_2_i,
             src1_1_i, src1_2_i, src2_1_i, src2_2_i, src1v_1_i, src1v_2_i, src2v_1_i, src2v_2_i,
             cdb_valid_i, cdb_tag_i, cdb_data_i, issue_ready_i,
      input  busy_o, issue_valid_o, issue_entry_o, issue_op_o, issue_dst_o, issue_src1_o, issue_src2_o
   );
   modport slave (
      input  flush_i, we_1_i, we_2_i, waddr_1_i, waddr_2_i, op_1_i, op_2_i, dst_1_i, dst_2_i,
             src1_1_i, src1_2_i, src2_1_i, src2_2_i, src1v_1_i, src1v_2_i, src2v_1_i, src2v_2_i,
             cdb_valid_i, cdb_tag_i, cdb_data_i, issue_ready_i,
      output busy_o, issue_valid_o, issue_entry_o, issue_op_o, issue_dst_o, issue_src1_o, issue_src2_o
   );
endinterface

// File: rtl/reservation_station.sv
// reservation_station: issue-queue entry storage with dual dispatch, CDB wakeup/bypass and in-order-by-index issue
module reservation_station #(
   parameter int ENTRY_NUM = 4,
   parameter int ENTRY_SEL = 2,
   parameter int DATA_LEN  = 32,
   parameter int TAG_LEN   = 6,
   parameter int OP_LEN    = 4
) (
   input logic clk_i,
   input logic reset_i,
   reservation_station_if.slave rs
);
   logic [ENTRY_NUM-1:0]               busy_q, busy_d, src1v_q, src1v_d, src2v_q, src2v_d;
   logic [ENTRY_NUM-1:0][OP_LEN-1:0]   op_q, op_d;
   logic [ENTRY_NUM-1:0][TAG_LEN-1:0]  dst_q, dst_d;
   logic [ENTRY_NUM-1:0][DATA_LEN-1:0] src1_q, src1_d, src2_q, src2_d;
   logic [ENTRY_NUM-1:0]               ready;
   logic [ENTRY_SEL-1:0]               sel;
   logic                               valid;
   logic                               b11, b12, b21, b22;

   function automatic logic hit(input logic v, input logic [TAG_LEN-1:0] t, input logic cv,
                                input logic [TAG_LEN-1:0] ct);
      return !v && cv && (t == ct);
   endfunction

   always_comb begin
      busy_d  = busy_q;
      src1v_d = src1v_q;
      src2v_d = src2v_q;
      op_d    = op_q;
      dst_d   = dst_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      ready   = busy_q & src1v_q & src2v_q;
      sel     = '0;
      for (int i = ENTRY_NUM-1; i >= 0; i--) if (ready[i]) sel = ENTRY_SEL'(i);
      valid   = |ready && !rs.flush_i;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (busy_q[i] && hit(src1v_q[i], src1_q[i][TAG_LEN-1:0], rs.cdb_valid_i, rs.cdb_tag_i)) begin
            src1_d[i]  = rs.cdb_data_i;
            src1v_d[i] = 1'b1;
         end
         if (busy_q[i] && hit(src2v_q[i], src2_q[i][TAG_LEN-1:0], rs.cdb_valid_i, rs.cdb_tag_i)) begin
            src2_d[i]  = rs.cdb_data_i;
            src2v_d[i] = 1'b1;
         end
      end
      if (valid && rs.issue_ready_i) busy_d[sel] = 1'b0;
      // writes follow the issue free so a dispatch into the issuing entry wins; slot 2 after slot 1
      b11 = hit(rs.src1v_1_i, rs.src1_1_i[TAG_LEN-1:0], rs.cdb_valid_i, rs.cdb_tag_i);
      b21 = hit(rs.src2v_1_i, rs.src2_1_i[TAG_LEN-1:0], rs.cdb_valid_i, rs.cdb_tag_i);
      b12 = hit(rs.src1v_2_i, rs.src1_2_i[TAG_LEN-1:0], rs.cdb_valid_i, rs.cdb_tag_i);
      b22 = hit(rs.src2v_2_i, rs.src2_2_i[TAG_LEN-1:0], rs.cdb_valid_i, rs.cdb_tag_i);
      if (rs.we_1_i) begin
         busy_d[rs.waddr_1_i]  = 1'b1;
         op_d[rs.waddr_1_i]    = rs.op_1_i;
         dst_d[rs.waddr_1_i]   = rs.dst_1_i;
         src1_d[rs.waddr_1_i]  = b11 ? rs.cdb_data_i : rs.src1_1_i;
         src1v_d[rs.waddr_1_i] = rs.src1v_1_i || b11;
         src2_d[rs.waddr_1_i]  = b21 ? rs.cdb_data_i : rs.src2_1_i;
         src2v_d[rs.waddr_1_i] = rs.src2v_1_i || b21;
      end
      if (rs.we_2_i) begin
         busy_d[rs.waddr_2_i]  = 1'b1;
         op_d[rs.waddr_2_i]    = rs.op_2_i;
         dst_d[rs.waddr_2_i]   = rs.dst_2_i;
         src1_d[rs.waddr_2_i]  = b12 ? rs.cdb_data_i : rs.src1_2_i;
         src1v_d[rs.waddr_2_i] = rs.src1v_2_i || b12;
         src2_d[rs.waddr_2_i]  = b22 ? rs.cdb_data_i : rs.src2_2_i;
         src2v_d[rs.waddr_2_i] = rs.src2v_2_i || b22;
      end
      if (rs.flush_i) busy_d = '0;
      rs.busy_o        = busy_q;
      rs.issue_valid_o = valid;
      rs.issue_entry_o = valid ? sel : '0;
      rs.issue_op_o    = valid ? op_q[sel] : '0;
      rs.issue_dst_o   = valid ? dst_q[sel] : '0;
      rs.issue_src1_o  = valid ? src1_q[sel] : '0;
      rs.issue_src2_o  = valid ? src2_q[sel] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q  <= '0;
         src1v_q <= '0;
         src2v_q <= '0;
         op_q    <= '0;
         dst_q   <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         src1v_q <= src1v_d;
         src2v_q <= src2v_d;
         op_q    <= op_d;
         dst_q   <= dst_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed plus random stimulus against a behavioural entry-table model
module tb_reservation_station;
   localparam int EN = 4, ES = 2, DL = 32, TL = 6, OL = 4;

   typedef struct {
      logic          busy;
      logic [OL-1:0] op;
      logic [TL-1:0] dst;
      logic [DL-1:0] s1, s2;
      logic          v1, v2;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   ent_t m [EN];
   int   vecs = 0, errs = 0;

   always #5 clk = ~clk;

   reservation_station_if #(.ENTRY_NUM(EN), .ENTRY_SEL(ES), .DATA_LEN(DL), .TAG_LEN(TL), .OP_LEN(OL)) bus ();
   reservation_station #(.ENTRY_NUM(EN), .ENTRY_SEL(ES), .DATA_LEN(DL), .TAG_LEN(TL), .OP_LEN(OL)) dut (
      .clk_i(clk), .reset_i(rst), .rs(bus));

   task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [OL-1:0] op, input logic [TL-1:0] dst,
                               input logic [DL-1:0] s1, input logic v1, input logic [DL-1:0] s2, input logic v2);
      ent_t e;
      e.busy = 1'b1; e.op = op; e.dst = dst;
      e.v1 = v1; e.s1 = s1; e.v2 = v2; e.s2 = s2;
      if (!v1 && bus.cdb_valid_i && s1[TL-1:0] == bus.cdb_tag_i) begin e.s1 = bus.cdb_data_i; e.v1 = 1'b1; end
      if (!v2 && bus.cdb_valid_i && s2[TL-1:0] == bus.cdb_tag_i) begin e.s2 = bus.cdb_data_i; e.v2 = 1'b1; end
      return e;
   endfunction

   task automatic idle();
      bus.we_1_i = 0; bus.we_2_i = 0; bus.flush_i = 0; bus.cdb_valid_i = 0;
      bus.waddr_1_i = 0; bus.waddr_2_i = 0; bus.op_1_i = 0; bus.op_2_i = 0; bus.dst_1_i = 0; bus.dst_2_i = 0;
      bus.src1_1_i = 0; bus.src2_1_i = 0; bus.src1_2_i = 0; bus.src2_2_i = 0;
      bus.src1v_1_i = 0; bus.src2v_1_i = 0; bus.src1v_2_i = 0; bus.src2v_2_i = 0;
      bus.cdb_tag_i = 0; bus.cdb_data_i = 0;
   endtask

   task automatic disp(input int slot, input int a, input int op, input int dst,
                       input logic [DL-1:0] s1, input logic v1, input logic [DL-1:0] s2, input logic v2);
      if (slot == 1) begin
         bus.we_1_i = 1; bus.waddr_1_i = ES'(a); bus.op_1_i = OL'(op); bus.dst_1_i = TL'(dst);
         bus.src1_1_i = s1; bus.src1v_1_i = v1; bus.src2_1_i = s2; bus.src2v_1_i = v2;
      end else begin
         bus.we_2_i = 1; bus.waddr_2_i = ES'(a); bus.op_2_i = OL'(op); bus.dst_2_i = TL'(dst);
         bus.src1_2_i = s1; bus.src1v_2_i = v1; bus.src2_2_i = s2; bus.src2v_2_i = v2;
      end
   endtask

   // check outputs mid-cycle, derive the model's next state from current inputs, then advance one clock
   task automatic cycle();
      ent_t n [EN];
      int sel;
      logic any, v;
      logic [EN-1:0] bz;
      #1;
      any = 0; sel = 0;
      for (int i = EN-1; i >= 0; i--) if (m[i].busy && m[i].v1 && m[i].v2) begin any = 1; sel = i; end
      v = any && !bus.flush_i;
      for (int i = 0; i < EN; i++) bz[i] = m[i].busy;
      chk("busy", DL'(bus.busy_o), DL'(bz));
      chk("issue_valid", DL'(bus.issue_valid_o), DL'(v));
      chk("issue_entry", DL'(bus.issue_entry_o), v ? DL'(sel) : 0);
      chk("issue_op", DL'(bus.issue_op_o), v ? DL'(m[sel].op) : 0);
      chk("issue_dst", DL'(bus.issue_dst_o), v ? DL'(m[sel].dst) : 0);
      chk("issue_src1", bus.issue_src1_o, v ? m[sel].s1 : 0);
      chk("issue_src2", bus.issue_src2_o, v ? m[sel].s2 : 0);
      n = m;
      for (int i = 0; i < EN; i++) if (m[i].busy && bus.cdb_valid_i) begin
         if (!m[i].v1 && m[i].s1[TL-1:0] == bus.cdb_tag_i) begin n[i].s1 = bus.cdb_data_i; n[i].v1 = 1; end
         if (!m[i].v2 && m[i].s2[TL-1:0] == bus.cdb_tag_i) begin n[i].s2 = bus.cdb_data_i; n[i].v2 = 1; end
      end
      if (v && bus.issue_ready_i) n[sel].busy = 0;
      if (bus.we_1_i) n[bus.waddr_1_i] = mk(bus.op_1_i, bus.dst_1_i, bus.src1_1_i, bus.src1v_1_i, bus.src2_1_i, bus.src2v_1_i);
      if (bus.we_2_i) n[bus.waddr_2_i] = mk(bus.op_2_i, bus.dst_2_i, bus.src1_2_i, bus.src1v_2_i, bus.src2_2_i, bus.src2v_2_i);
      if (bus.flush_i) for (int i = 0; i < EN; i++) n[i].busy = 0;
      if (rst) for (int i = 0; i < EN; i++) n[i] = '{0, 0, 0, 0, 0, 0, 0};
      @(posedge clk);
      m = n;
      @(negedge clk);
   endtask

   initial begin
      idle();
      bus.issue_ready_i = 1;
      rst = 1;
      for (int i = 0; i < EN; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      cycle();
      rst = 0;
      // dual dispatch of ready instructions into entries 0 and 2
      disp(1, 0, 3, 10, 32'h11, 1, 32'h22, 1);
      disp(2, 2, 5, 11, 32'h33, 1, 32'h44, 1);
      cycle(); idle();
      repeat (3) cycle();
      // wakeup on tag 9, unrelated tag 8 first
      disp(1, 1, 7, 12, 32'h9, 0, 32'h55, 1);
      cycle(); idle();
      bus.cdb_valid_i = 1; bus.cdb_tag_i = 8; bus.cdb_data_i = 32'h12345678;
      cycle();
      bus.cdb_tag_i = 9; bus.cdb_data_i = 32'hDEADBEEF;
      cycle(); idle();
      repeat (2) cycle();
      // write-time bypass on src2 tag 5
      disp(1, 3, 2, 13, 32'h66, 1, 32'hFFFF_FF05, 0);
      bus.cdb_valid_i = 1; bus.cdb_tag_i = 5; bus.cdb_data_i = 32'h42;
      cycle(); idle();
      repeat (2) cycle();
      // backpressure with entries 0,1,3 ready
      bus.issue_ready_i = 0;
      disp(1, 0, 1, 20, 1, 1, 2, 1);
      disp(2, 1, 2, 21, 3, 1, 4, 1);
      cycle(); idle();
      disp(1, 3, 4, 23, 5, 1, 6, 1);
      cycle(); idle();
      repeat (3) cycle();
      bus.issue_ready_i = 1;
      repeat (4) cycle();
      // flush with a same-cycle write
      bus.issue_ready_i = 0;
      disp(1, 0, 1, 30, 1, 1, 2, 1);
      disp(2, 1, 2, 31, 3, 1, 4, 1);
      cycle(); idle();
      disp(1, 3, 3, 33, 5, 1, 6, 0);
      cycle(); idle();
      bus.issue_ready_i = 1; bus.flush_i = 1;
      disp(1, 2, 6, 32, 7, 1, 8, 1);
      cycle(); idle();
      repeat (2) cycle();
      // random traffic with small tag space to provoke wakeups, bypasses and collisions
      for (int k = 0; k < 400; k++) begin
         idle();
         rst = ($urandom_range(0, 99) == 0);
         bus.flush_i = ($urandom_range(0, 29) == 0);
         bus.issue_ready_i = ($urandom_range(0, 9) < 7);
         bus.cdb_valid_i = $urandom_range(0, 1);
         bus.cdb_tag_i = TL'($urandom_range(0, 7));
         bus.cdb_data_i = $urandom;
         for (int s = 1; s <= 2; s++) if ($urandom_range(0, 1) == 1)
            disp(s, $urandom_range(0, EN-1), $urandom_range(0, 15), $urandom_range(0, 63),
                 ($urandom & ~32'h3F) | DL'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom & ~32'h3F) | DL'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         cycle();
      end
      rst = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
